regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register file's single write port (WE3/A3/WD3) between two sources.
//  - Primary: the in-order pipeline writeback.
//  - Secondary: a long-latency unit (e.g. load/mul-div) returning results out of order.
//  Secondary results are buffered in a small FIFO and written on idle port cycles.
//  A per-register busy scoreboard and a starvation stall request go to the hazard unit.
// PARAMETERS
//  ADDR_WIDTH   5   register address width (2**ADDR_WIDTH registers)
//  DATA_WIDTH   32  register data width
//  FIFO_DEPTH   2   secondary-result buffer entries (power of 2, >=2)
//  STARVE_LIMIT 4   consecutive blocked cycles before stall_req asserts
// PORTS
//  clk        in   1              clock
//  rst        in   1              synchronous reset, active-high
//  wb_en      in   1              primary write request (always accepted)
//  wb_rd      in   ADDR_WIDTH     primary destination register
//  wb_data    in   DATA_WIDTH     primary write data
//  lsu_valid  in   1              secondary result valid
//  lsu_ready  out  1              secondary result accepted this cycle
//  lsu_rd     in   ADDR_WIDTH     secondary destination register
//  lsu_data   in   DATA_WIDTH     secondary write data
//  issue_en   in   1              long-latency op issued; mark issue_rd busy
//  issue_rd   in   ADDR_WIDTH     destination of the issued op
//  busy       out  2**ADDR_WIDTH  scoreboard, bit r = write to xr outstanding
//  stall_req  out  1              ask hazard unit to bubble the pipeline
//  WE3        out  1              regfile write enable
//  A3         out  ADDR_WIDTH     regfile write address
//  WD3        out  DATA_WIDTH     regfile write data
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge):
//  - FIFO emptied (buffered writes discarded), busy=0, count=0, state=NORMAL.
//  - While rst=1: WE3=0, lsu_ready=0, stall_req=0.
//  Handshake:
//  - lsu_ready = !full. This is conservative: no credit is given for a same-cycle pop.
//  - Push on lsu_valid && lsu_ready. A push with lsu_rd==0 is accepted and dropped (not stored).
//  Port select (combinational, same cycle):
//  - If wb_en && wb_rd!=0: WE3=1, A3=wb_rd, WD3=wb_data.
//  - Else if FIFO non-empty: WE3=1, A3/WD3 = head entry; pop at the edge.
//  - Else WE3=0, A3=0, WD3=0.
//  - wb_en with wb_rd==0 is a no-op and leaves the port free for the FIFO.
//  - Minimum secondary latency: accepted at edge N, written at edge N+1. No bypass.
//  - Simultaneous push and pop is legal. Occupancy stays unchanged; FIFO order is strict.
//  Scoreboard:
//  - On issue_en && issue_rd!=0, busy[issue_rd] is set at the edge.
//  - On a pop, busy[head.rd] is cleared.
//  - Set and clear of the same register in one cycle: set wins.
//  - busy[0] is always 0.
//  - Primary writes never modify busy.
//  FSM arb_state_t:
//  - NORMAL: count increments while the FIFO is non-empty and the primary wins the port.
//    count resets to 0 on any pop or when the FIFO is empty.
//    count==STARVE_LIMIT-1 and blocked -> STARVED.
//  - STARVED: stall_req=1 (registered, asserted from the cycle after the transition).
//    First pop -> NORMAL, count=0.
//  - The primary keeps priority even in STARVED. stall_req only requests a bubble.
// STRUCTURE
//  - regfile_pkg: ADDR_WIDTH/DATA_WIDTH defaults, wb_req_t {rd, data},
//    arb_state_t {NORMAL, STARVED}.
//  - Sub-module wb_fifo: synchronous FIFO of wb_req_t, ptr wrap via extra MSB,
//    full/empty flags.
//  - Top-level logic: port mux, scoreboard register, FSM + counter.
// TESTING
//  T1 reset: rst for 2 cycles with wb_en=1 -> WE3=0, busy=0, lsu_ready=0.
//     Then rst=0 -> lsu_ready=1.
//  T2 primary only: wb_en=1, rd=5, data=0xDEAD -> same cycle WE3=1, A3=5, WD3=0xDEAD.
//     rd=0 -> WE3=0.
//  T3 secondary: issue_rd=7, then lsu rd=7, data=0x1234 at edge N, wb_en=0.
//     -> edge N+1 WE3=1, A3=7, busy[7] 1->0.
//  T4 contention: FIFO holds rd=3 and rd=4, wb_en=1 for 6 cycles.
//     -> lsu_ready=0 while full, stall_req=1 from cycle 5.
//     wb_en=0 -> writes x3 then x4, stall_req drops after the first pop.
//  T5 scoreboard race: issue_rd=9 in the same cycle a pop of rd=9 -> busy[9] stays 1.
//     lsu rd=0 push -> no WE3, busy unchanged.
//  T6 reset mid-op: FIFO with 2 entries, busy[3], busy[4] set, rst pulse
//     -> FIFO empty, no further WE3, busy=0.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
package regfile_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 5;
    localparam int DEFAULT_DATA_WIDTH = 32;

    // One pending register write: destination and value.
    typedef struct packed {
        logic [DEFAULT_ADDR_WIDTH-1:0] rd;
        logic [DEFAULT_DATA_WIDTH-1:0] data;
    } wb_req_t;

    // NORMAL: secondary results drain on idle port cycles.
    // STARVED: the FIFO has been blocked too long; ask for a pipeline bubble.
    typedef enum logic {
        NORMAL  = 1'b0,
        STARVED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// Small synchronous FIFO that holds secondary (out-of-order) write results.
// Pointers carry one extra MSB so full and empty can be told apart.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = wb_req_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    localparam int PW = $clog2(DEPTH);

    entry_t         mem [DEPTH];
    logic [PW:0]    wr_ptr;
    logic [PW:0]    rd_ptr;
    logic           push_ok;
    logic           pop_ok;

    // Ignore a push into a full buffer or a pop from an empty one.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointer update; reset discards every buffered entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + (PW+1)'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + (PW+1)'(1);
            end
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[PW-1:0]] <= push_data;
        end
    end

    assign head  = mem[rd_ptr[PW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                   (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between the in-order writeback
// (always wins) and buffered long-latency results (written on idle cycles).
// Also keeps a per-register busy scoreboard and a starvation stall request.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_en,
    input  logic [ADDR_WIDTH-1:0]    wb_rd,
    input  logic [DATA_WIDTH-1:0]    wb_data,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [ADDR_WIDTH-1:0]    lsu_rd,
    input  logic [DATA_WIDTH-1:0]    lsu_data,
    input  logic                     issue_en,
    input  logic [ADDR_WIDTH-1:0]    issue_rd,
    output logic [2**ADDR_WIDTH-1:0] busy,
    output logic                     stall_req,
    output logic                     WE3,
    output logic [ADDR_WIDTH-1:0]    A3,
    output logic [DATA_WIDTH-1:0]    WD3
);

    localparam int NREGS = 2**ADDR_WIDTH;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } req_t;

    req_t             push_entry;
    req_t             fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             primary_win;
    logic             blocked;

    logic [NREGS-1:0] busy_next;
    arb_state_t       state;
    arb_state_t       state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    // A write to x0 has no effect, so it never claims the port.
    assign primary_win = wb_en && (wb_rd != '0);

    // Accept only when there is room now; a same-cycle pop earns no credit.
    assign lsu_ready  = !rst && !fifo_full;
    assign push       = lsu_valid && lsu_ready && (lsu_rd != '0);
    assign push_entry = '{rd: lsu_rd, data: lsu_data};

    // The buffer drains only when the primary leaves the port free.
    assign pop     = !rst && !primary_win && !fifo_empty;
    assign blocked = primary_win && !fifo_empty;

    wb_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (req_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Write-port mux: primary first, then the FIFO head, otherwise idle.
    always_comb begin
        WE3 = 1'b0;
        A3  = '0;
        WD3 = '0;
        if (!rst) begin
            if (primary_win) begin
                WE3 = 1'b1;
                A3  = wb_rd;
                WD3 = wb_data;
            end else if (!fifo_empty) begin
                WE3 = 1'b1;
                A3  = fifo_head.rd;
                WD3 = fifo_head.data;
            end
        end
    end

    // Scoreboard next value: a new issue beats a same-cycle retire; x0 never busy.
    always_comb begin
        busy_next = busy;
        if (pop) begin
            busy_next[fifo_head.rd] = 1'b0;
        end
        if (issue_en && (issue_rd != '0)) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Starvation FSM state and blocked-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= NORMAL;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Starvation FSM next state; stall_req follows the registered state.
    always_comb begin
        state_next = state;
        count_next = count;
        stall_req  = !rst && (state == STARVED);
        case (state)
            NORMAL: begin
                if (pop || fifo_empty) begin
                    count_next = '0;
                end else if (blocked) begin
                    if (count == CNT_W'(STARVE_LIMIT - 1)) begin
                        state_next = STARVED;
                        count_next = '0;
                    end else begin
                        count_next = count + CNT_W'(1);
                    end
                end
            end
            STARVED: begin
                count_next = '0;
                if (pop) begin
                    state_next = NORMAL;
                end
            end
            default: begin
                state_next = NORMAL;
                count_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic [31:0] busy;
    logic        stall_req;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;

    int checks   = 0;
    int failures = 0;

    regfile_wb_arbiter #(
        .ADDR_WIDTH   (5),
        .DATA_WIDTH   (32),
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .issue_en  (issue_en),
        .issue_rd  (issue_rd),
        .busy      (busy),
        .stall_req (stall_req),
        .WE3       (WE3),
        .A3        (A3),
        .WD3       (WD3)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic we, input logic [4:0] wrd, input logic [31:0] wdat,
                                  input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                                  input logic ie, input logic [4:0] ird);
        wb_en     = we;
        wb_rd     = wrd;
        wb_data   = wdat;
        lsu_valid = lv;
        lsu_rd    = lrd;
        lsu_data  = ldat;
        issue_en  = ie;
        issue_rd  = ird;
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        // T1: reset with a pending primary write
        rst = 1'b1;
        apply_stimulus(1, 5'd5, 32'h1111, 0, 0, 0, 0, 0);
        tick();
        check_output("t1_we3_in_rst", WE3, 0);
        check_output("t1_ready_in_rst", lsu_ready, 0);
        check_output("t1_stall_in_rst", stall_req, 0);
        tick();
        check_output("t1_busy_in_rst", busy, 0);
        check_output("t1_we3_in_rst2", WE3, 0);
        rst = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        check_output("t1_ready_after", lsu_ready, 1);
        check_output("t1_we3_after", WE3, 0);

        // T2: primary only, same-cycle write; x0 is a no-op
        apply_stimulus(1, 5'd5, 32'hDEAD, 0, 0, 0, 0, 0);
        check_output("t2_we3", WE3, 1);
        check_output("t2_a3", A3, 5);
        check_output("t2_wd3", WD3, 32'hDEAD);
        tick();
        apply_stimulus(1, 5'd0, 32'hBEEF, 0, 0, 0, 0, 0);
        check_output("t2_x0_we3", WE3, 0);
        check_output("t2_x0_a3", A3, 0);
        tick();

        // T3: issue x7, then secondary result, written one edge later
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 5'd7);
        tick();
        check_output("t3_busy_set", busy, 32'h0000_0080);
        apply_stimulus(0, 0, 0, 1, 5'd7, 32'h1234, 0, 0);
        check_output("t3_ready", lsu_ready, 1);
        check_output("t3_no_bypass", WE3, 0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        check_output("t3_we3", WE3, 1);
        check_output("t3_a3", A3, 7);
        check_output("t3_wd3", WD3, 32'h1234);
        check_output("t3_busy_pending", busy, 32'h0000_0080);
        tick();
        check_output("t3_we3_done", WE3, 0);
        check_output("t3_busy_clear", busy, 0);

        // T4: contention; fill FIFO with x3, x4 while primary holds the port
        apply_stimulus(1, 5'd10, 32'hAAAA, 1, 5'd3, 32'h3333, 1, 5'd3);
        check_output("t4_p1_a3", A3, 10);
        tick();
        apply_stimulus(1, 5'd10, 32'hAAAA, 1, 5'd4, 32'h4444, 1, 5'd4);
        check_output("t4_p2_ready", lsu_ready, 1);
        check_output("t4_p2_a3", A3, 10);
        tick();
        apply_stimulus(1, 5'd10, 32'hAAAA, 1, 5'd11, 32'hBBBB, 0, 0);
        check_output("t4_full_ready", lsu_ready, 0);
        check_output("t4_busy34", busy, 32'h0000_0018);
        check_output("t4_b1_stall", stall_req, 0);
        tick();
        check_output("t4_b2_stall", stall_req, 0);
        tick();
        check_output("t4_b3_stall", stall_req, 0);
        tick();
        check_output("t4_b4_stall", stall_req, 1);
        check_output("t4_b4_prio_a3", A3, 10);
        check_output("t4_b4_ready", lsu_ready, 0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        check_output("t4_d1_a3", A3, 3);
        check_output("t4_d1_wd3", WD3, 32'h3333);
        check_output("t4_d1_stall", stall_req, 1);
        tick();
        check_output("t4_d2_we3", WE3, 1);
        check_output("t4_d2_a3", A3, 4);
        check_output("t4_d2_wd3", WD3, 32'h4444);
        check_output("t4_d2_stall", stall_req, 0);
        check_output("t4_d2_busy", busy, 32'h0000_0010);
        check_output("t4_d2_ready", lsu_ready, 1);
        tick();
        check_output("t4_d3_we3", WE3, 0);
        check_output("t4_d3_busy", busy, 0);

        // T5: issue x9 in the same cycle x9 retires -> stays busy
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 5'd9);
        tick();
        apply_stimulus(0, 0, 0, 1, 5'd9, 32'h9999, 0, 0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 5'd9);
        check_output("t5_pop_a3", A3, 9);
        check_output("t5_pop_wd3", WD3, 32'h9999);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        check_output("t5_busy_race", busy, 32'h0000_0200);
        check_output("t5_we3_idle", WE3, 0);
        apply_stimulus(0, 0, 0, 1, 5'd0, 32'h5555, 0, 0);
        check_output("t5_x0_ready", lsu_ready, 1);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        check_output("t5_x0_dropped", WE3, 0);
        check_output("t5_x0_busy", busy, 32'h0000_0200);

        // T6: reset while FIFO holds two entries and x3/x4 are busy
        apply_stimulus(1, 5'd12, 32'hCCCC, 1, 5'd3, 32'h0303, 1, 5'd3);
        tick();
        apply_stimulus(1, 5'd12, 32'hCCCC, 1, 5'd4, 32'h0404, 1, 5'd4);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        check_output("t6_busy_before", busy, 32'h0000_0218);
        check_output("t6_full", lsu_ready, 0);
        check_output("t6_head_a3", A3, 3);
        rst = 1'b1;
        #1;
        check_output("t6_we3_in_rst", WE3, 0);
        check_output("t6_ready_in_rst", lsu_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        check_output("t6_we3_after", WE3, 0);
        check_output("t6_busy_after", busy, 0);
        check_output("t6_ready_after", lsu_ready, 1);
        check_output("t6_stall_after", stall_req, 0);
        tick();
        check_output("t6_we3_later", WE3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
